// File: rtl/change_dispenser.sv
// change_dispenser: greedy change payout through a three-tube (5/2/1) coin hopper.
// Ejects one coin at a time under a pulse/acknowledge handshake, tracks per-tube
// coin counts, and raises a sticky fault on an empty tube or a hopper timeout.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-low reset
//   start      one-cycle request to dispense `amount` (accepted in IDLE/FAULT)
//   amount     change to dispense, in units
//   refill     one-cycle pulse, reloads all tubes to TUBE_INIT (IDLE/FAULT only)
//   hopper_ack hopper confirms one coin dropped
//   eject      one-hot {eject5, eject2, eject1} strobe to the hopper
//   busy       high while a dispense is in progress (SELECT through DONE)
//   remaining  units still to dispense
//   done       one-cycle completion pulse
//   fault      sticky error, cleared by the next accepted start or reset
//   tube5/2/1  current coin count per tube
module change_dispenser #(
  parameter int unsigned PULSE_CYCLES   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned TUBE_INIT      = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] amount,
  input  logic       refill,
  input  logic       hopper_ack,
  output logic [2:0] eject,
  output logic       busy,
  output logic [7:0] remaining,
  output logic       done,
  output logic       fault,
  output logic [3:0] tube5,
  output logic [3:0] tube2,
  output logic [3:0] tube1
);

  localparam int unsigned CMAX = (PULSE_CYCLES > TIMEOUT_CYCLES) ? PULSE_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    EJECT,
    WAIT_ACK,
    DONE,
    FAULT
  } state_t;

  state_t        state, state_nx;
  logic [2:0]    coin;        // latched one-hot denomination {5,2,1}
  logic [2:0]    coin_pick;
  logic [7:0]    coin_val;
  logic [7:0]    rem_left;
  logic [CW-1:0] cnt;         // shared pulse-width / timeout counter
  logic          zero_done;   // DONE reached via amount=0: keep busy low
  logic          accept;
  logic          take;
  logic          refill_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    coin_pick = '0;
    accept    = 1'b0;
    take      = 1'b0;
    refill_ok = 1'b0;

    unique case (coin)
      3'b100:  coin_val = 8'd5;
      3'b010:  coin_val = 8'd2;
      3'b001:  coin_val = 8'd1;
      default: coin_val = 8'd0;
    endcase
    rem_left = remaining - coin_val;

    // Greedy pick: largest denomination that fits and whose tube is non-empty.
    if (remaining >= 8'd5 && tube5 != 4'd0)      coin_pick = 3'b100;
    else if (remaining >= 8'd2 && tube2 != 4'd0) coin_pick = 3'b010;
    else if (remaining >= 8'd1 && tube1 != 4'd0) coin_pick = 3'b001;

    unique case (state)
      IDLE, FAULT: begin
        refill_ok = refill;
        if (start) begin
          accept   = 1'b1;
          state_nx = (amount == 8'd0) ? DONE : SELECT;
        end
      end
      SELECT:   state_nx = (coin_pick == 3'b000) ? FAULT : EJECT;
      EJECT:    if (cnt == CW'(PULSE_CYCLES - 1)) state_nx = WAIT_ACK;
      WAIT_ACK: begin
        // An ack on the final timeout cycle wins over the timeout.
        if (hopper_ack) begin
          take     = 1'b1;
          state_nx = (rem_left == 8'd0) ? DONE : SELECT;
        end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          state_nx = FAULT;
        end
      end
      DONE:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      remaining <= '0;
      coin      <= '0;
      cnt       <= '0;
      zero_done <= 1'b0;
      tube5     <= 4'(TUBE_INIT);
      tube2     <= 4'(TUBE_INIT);
      tube1     <= 4'(TUBE_INIT);
    end else begin
      if (accept) begin
        remaining <= amount;
        zero_done <= (amount == 8'd0);
      end
      if (refill_ok) begin
        tube5 <= 4'(TUBE_INIT);
        tube2 <= 4'(TUBE_INIT);
        tube1 <= 4'(TUBE_INIT);
      end
      if (state == SELECT) coin <= coin_pick;
      if (take) begin
        remaining <= rem_left;
        if (coin[2]) tube5 <= tube5 - 4'd1;
        if (coin[1]) tube2 <= tube2 - 4'd1;
        if (coin[0]) tube1 <= tube1 - 4'd1;
      end
      // Counter restarts on every state change so WAIT_ACK always begins at 0.
      if ((state == EJECT || state == WAIT_ACK) && state_nx == state)
        cnt <= cnt + CW'(1);
      else
        cnt <= '0;
    end
  end

  always_comb begin
    eject = (state == EJECT) ? coin : 3'b000;
    busy  = (state inside {SELECT, EJECT, WAIT_ACK}) || (state == DONE && !zero_done);
    done  = (state == DONE);
    fault = (state == FAULT);
  end

endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: table-driven cycle vectors for nominal, ignored-input and
// zero-amount behaviour, plus hand-written sequences for depletion, timeout,
// last-cycle ack and asynchronous reset mid-eject.
module tb_change_dispenser;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] amount;
  logic       refill;
  logic       hopper_ack;

  logic [2:0] a_eject, b_eject;
  logic       a_busy, b_busy, a_done, b_done, a_fault, b_fault;
  logic [7:0] a_rem, b_rem;
  logic [3:0] a_t5, a_t2, a_t1, b_t5, b_t2, b_t1;

  int tests;
  int fails;

  change_dispenser #(.PULSE_CYCLES(4), .TIMEOUT_CYCLES(10), .TUBE_INIT(15)) u_a (
    .clk(clk), .rst(rst), .start(start), .amount(amount), .refill(refill),
    .hopper_ack(hopper_ack), .eject(a_eject), .busy(a_busy), .remaining(a_rem),
    .done(a_done), .fault(a_fault), .tube5(a_t5), .tube2(a_t2), .tube1(a_t1)
  );

  change_dispenser #(.PULSE_CYCLES(4), .TIMEOUT_CYCLES(10), .TUBE_INIT(1)) u_b (
    .clk(clk), .rst(rst), .start(start), .amount(amount), .refill(refill),
    .hopper_ack(hopper_ack), .eject(b_eject), .busy(b_busy), .remaining(b_rem),
    .done(b_done), .fault(b_fault), .tube5(b_t5), .tube2(b_t2), .tube1(b_t1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       start;
    logic [7:0] amount;
    logic       refill;
    logic       ack;
    logic [2:0] ej;
    logic       busy;
    logic       done;
    logic [7:0] rem;
    logic [3:0] t5, t2, t1;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic s, input logic [7:0] a, input logic rf, input logic ak,
                     input logic [2:0] ej, input logic bz, input logic dn, input logic [7:0] rem,
                     input logic [3:0] t5, input logic [3:0] t2, input logic [3:0] t1, input int n);
    vec_t v;
    v.start = s; v.amount = a; v.refill = rf; v.ack = ak;
    v.ej = ej; v.busy = bz; v.done = dn; v.rem = rem;
    v.t5 = t5; v.t2 = t2; v.t1 = t1;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic reset_all();
    rst = 1'b0; start = 1'b0; amount = '0; refill = 1'b0; hopper_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // Wait (bounded) for DUT a's strobe to rise, then fall: returns in first WAIT_ACK cycle.
  task automatic a_to_wait(input string name);
    int k;
    k = 0;
    while (a_eject == 3'b000 && k < 20) begin @(posedge clk); #1; k++; end
    chk({name, "_strobe_seen"}, 64'(k < 20), 64'd1);
    k = 0;
    while (a_eject != 3'b000 && k < 20) begin @(posedge clk); #1; k++; end
    chk({name, "_strobe_width"}, 64'(k), 64'd4);
  endtask

  // One coin on DUT b: check denomination, reach WAIT_ACK, ack on its first cycle.
  task automatic coin_b(input logic [2:0] exp);
    int k;
    k = 0;
    while (b_eject == 3'b000 && k < 20) begin @(posedge clk); #1; k++; end
    chk("b_coin", 64'(b_eject), 64'(exp));
    k = 0;
    while (b_eject != 3'b000 && k < 20) begin @(posedge clk); #1; k++; end
    chk("b_reach_wait", 64'(k < 20), 64'd1);
    hopper_ack = 1'b1;
    @(posedge clk); #1;
    hopper_ack = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;

    // Nominal amount=8 from full tubes: 5, 2, 1, done at cycle 19.
    add(1, 8, 0, 0, 3'b000, 1, 0, 8, 15, 15, 15, 1);
    add(0, 0, 0, 0, 3'b100, 1, 0, 8, 15, 15, 15, 4);
    add(0, 0, 0, 0, 3'b000, 1, 0, 8, 15, 15, 15, 1);
    add(0, 0, 0, 1, 3'b000, 1, 0, 3, 14, 15, 15, 1);
    add(0, 0, 0, 0, 3'b010, 1, 0, 3, 14, 15, 15, 4);
    add(0, 0, 0, 0, 3'b000, 1, 0, 3, 14, 15, 15, 1);
    add(0, 0, 0, 1, 3'b000, 1, 0, 1, 14, 14, 15, 1);
    add(0, 0, 0, 0, 3'b001, 1, 0, 1, 14, 14, 15, 4);
    add(0, 0, 0, 0, 3'b000, 1, 0, 1, 14, 14, 15, 1);
    add(0, 0, 0, 1, 3'b000, 1, 1, 0, 14, 14, 14, 1);
    add(0, 0, 0, 0, 3'b000, 0, 0, 0, 14, 14, 14, 1);
    // amount=3 with start(9), refill and spurious acks while busy: all ignored.
    add(1, 3, 0, 0, 3'b000, 1, 0, 3, 14, 14, 14, 1);
    add(1, 9, 0, 0, 3'b010, 1, 0, 3, 14, 14, 14, 1);
    add(0, 0, 1, 0, 3'b010, 1, 0, 3, 14, 14, 14, 1);
    add(0, 0, 0, 1, 3'b010, 1, 0, 3, 14, 14, 14, 2);
    add(0, 0, 0, 1, 3'b000, 1, 0, 3, 14, 14, 14, 1);
    add(0, 0, 0, 1, 3'b000, 1, 0, 1, 14, 13, 14, 1);
    add(0, 0, 0, 0, 3'b001, 1, 0, 1, 14, 13, 14, 4);
    add(0, 0, 0, 0, 3'b000, 1, 0, 1, 14, 13, 14, 1);
    add(0, 0, 0, 1, 3'b000, 1, 1, 0, 14, 13, 13, 1);
    add(0, 0, 0, 0, 3'b000, 0, 0, 0, 14, 13, 13, 1);
    // Zero amount: done for one cycle, busy never rises.
    add(1, 0, 0, 0, 3'b000, 0, 1, 0, 14, 13, 13, 1);
    add(0, 0, 0, 0, 3'b000, 0, 0, 0, 14, 13, 13, 2);
    // Refill in IDLE.
    add(0, 0, 1, 0, 3'b000, 0, 0, 0, 15, 15, 15, 1);

    reset_all();
    chk("reset_state", {a_eject, a_busy, a_done, a_fault, a_rem, a_t5, a_t2, a_t1},
        {3'b000, 1'b0, 1'b0, 1'b0, 8'd0, 4'd15, 4'd15, 4'd15});

    foreach (vecs[i]) begin
      start = vecs[i].start; amount = vecs[i].amount;
      refill = vecs[i].refill; hopper_ack = vecs[i].ack;
      @(posedge clk); #1;
      chk($sformatf("vec%0d", i),
          {a_eject, a_busy, a_done, a_fault, a_rem, a_t5, a_t2, a_t1},
          {vecs[i].ej, vecs[i].busy, vecs[i].done, 1'b0, vecs[i].rem,
           vecs[i].t5, vecs[i].t2, vecs[i].t1});
    end
    start = 1'b0; amount = '0; refill = 1'b0; hopper_ack = 1'b0;

    // Depletion on the TUBE_INIT=1 instance.
    reset_all();
    start = 1'b1; amount = 8'd4;
    @(posedge clk); #1;
    start = 1'b0; amount = '0;
    coin_b(3'b010);
    coin_b(3'b001);
    @(posedge clk); #1;
    chk("depl_fault", {b_fault, b_busy, b_rem, b_t5, b_t2, b_t1},
        {1'b1, 1'b0, 8'd1, 4'd1, 4'd0, 4'd0});
    refill = 1'b1;
    @(posedge clk); #1;
    refill = 1'b0;
    chk("depl_refill", {b_fault, b_t5, b_t2, b_t1}, {1'b1, 4'd1, 4'd1, 4'd1});
    start = 1'b1; amount = 8'd1;
    @(posedge clk); #1;
    start = 1'b0; amount = '0;
    chk("depl_restart", {b_fault, b_busy}, {1'b0, 1'b1});
    coin_b(3'b001);
    chk("depl_done", {b_done, b_rem, b_t1}, {1'b1, 8'd0, 4'd0});

    // Timeout: never ack, fault exactly 10 cycles after entering WAIT_ACK.
    reset_all();
    start = 1'b1; amount = 8'd5;
    @(posedge clk); #1;
    start = 1'b0; amount = '0;
    a_to_wait("to");
    begin
      int first;
      first = 0;
      for (int k = 1; k <= 15; k++) begin
        @(posedge clk); #1;
        if (a_fault && first == 0) first = k;
      end
      chk("timeout_cycles", 64'(first), 64'd10);
    end
    chk("timeout_state", {a_fault, a_busy, a_rem, a_t5}, {1'b1, 1'b0, 8'd5, 4'd15});

    // Ack on the last timeout cycle is a success.
    start = 1'b1; amount = 8'd5;
    @(posedge clk); #1;
    start = 1'b0; amount = '0;
    chk("fault_cleared", {a_fault, a_busy}, {1'b0, 1'b1});
    a_to_wait("late");
    repeat (9) @(posedge clk);
    #1;
    chk("late_no_fault", 64'(a_fault), 64'd0);
    hopper_ack = 1'b1;
    @(posedge clk); #1;
    hopper_ack = 1'b0;
    chk("late_ack", {a_done, a_fault, a_rem, a_t5}, {1'b1, 1'b0, 8'd0, 4'd14});
    @(posedge clk); #1;

    // Asynchronous reset mid-EJECT.
    start = 1'b1; amount = 8'd8;
    @(posedge clk); #1;
    start = 1'b0; amount = '0;
    begin
      int k;
      k = 0;
      while (a_eject == 3'b000 && k < 20) begin @(posedge clk); #1; k++; end
      chk("rst_pre_eject", 64'(a_eject), 64'(3'b100));
    end
    #3 rst = 1'b0;
    #1;
    chk("rst_async", {a_eject, a_busy}, {3'b000, 1'b0});
    @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_release", {a_eject, a_busy, a_done, a_fault, a_rem, a_t5, a_t2, a_t1},
        {3'b000, 1'b0, 1'b0, 1'b0, 8'd0, 4'd15, 4'd15, 4'd15});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
